// File: rtl/fetch_mem_if_pkg.sv
// Shared definitions for the fetch/memory-interface stage and the
// control-unit stall logic.
//   state_t    : access sequencer states (IDLE/ACCESS/DONE/ERR)
//   acc_cmd_t  : commit actions captured when an access is launched
//   sext8      : sign-extend an 8-bit branch offset to a word
package fetch_mem_if_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  // What to do with the returned word at the DONE->IDLE edge.
  typedef struct packed {
    logic ir;   // load IR
    logic rd;   // load rd_data
    logic inc;  // increment PC
  } acc_cmd_t;

  function automatic logic [WORD_W-1:0] sext8(input logic [7:0] v);
    return {{(WORD_W-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register.
//   clk, reset : clock, synchronous active-low reset (PC <= RESET_PC)
//   ld         : load PC; sel=1 takes jmp_tgt, sel=0 takes PC+sext(ofs8)
//   inc        : PC <= PC+1 (ld has priority)
//   ofs8       : branch offset, IR[7:0]
//   jmp_tgt    : absolute jump target
//   pc         : current program counter
module fetch_pc
  import fetch_mem_if_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              inc,
  input  logic              sel,
  input  logic [7:0]        ofs8,
  input  logic [WORD_W-1:0] jmp_tgt,
  output logic [WORD_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!reset)   pc <= RESET_PC;
    else if (ld)  pc <= sel ? jmp_tgt : pc + sext8(ofs8);
    else if (inc) pc <= pc + WORD_W'(1);
  end

endmodule

// File: rtl/fetch_mem_if.sv
// Fetch/memory-interface stage. Holds PC and IR and turns single-cycle
// control strobes into a req/ack access to a wait-state memory, stalling
// the control unit (busy) while the access is outstanding.
//   clk, reset      : clock, synchronous active-low reset
//   pc_ld/pc_inc/pc_sel/jmp_tgt : PC controls
//   ir_ld/s_sel/mw_en : fetch / data read / data write commands
//   adr_sel/reg_adr/st_data    : address source and store data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata : memory port
//   PC, IR, rd_data : architectural outputs
//   busy            : stall to the control unit
//   err             : sticky access timeout, cleared only by reset
module fetch_mem_if
  import fetch_mem_if_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_ld,
  input  logic        pc_inc,
  input  logic        pc_sel,
  input  logic        ir_ld,
  input  logic        adr_sel,
  input  logic        s_sel,
  input  logic        mw_en,
  input  logic [15:0] reg_adr,
  input  logic [15:0] st_data,
  input  logic [15:0] jmp_tgt,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] PC,
  output logic [15:0] IR,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t      state, state_n;
  acc_cmd_t    cmd_q;
  logic [CW-1:0] wcnt;
  logic [15:0] data_q;
  logic        cmd;
  logic        pc_ld_en, pc_inc_en;

  assign cmd = ir_ld | s_sel | mw_en;

  // A load is taken whenever it is seen in IDLE; if it accompanies an
  // access, the access still uses the pre-load PC (latched at the same
  // edge) and the later increment is dropped so the load wins.
  assign pc_ld_en  = (state == IDLE) & pc_ld;
  assign pc_inc_en = (state == DONE) & cmd_q.inc;

  fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .reset   (reset),
    .ld      (pc_ld_en),
    .inc     (pc_inc_en),
    .sel     (pc_sel),
    .ofs8    (IR[7:0]),
    .jmp_tgt (jmp_tgt),
    .pc      (PC)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    mem_req = 1'b0;
    busy    = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE: begin
        busy = cmd;
        if (cmd) state_n = ACCESS;
      end
      ACCESS: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_ack)                        state_n = DONE;
        else if (wcnt == CW'(TIMEOUT - 1))  state_n = ERR;
      end
      DONE: state_n = IDLE;
      ERR: begin
        busy = 1'b1;
        err  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      IR        <= '0;
      rd_data   <= '0;
      data_q    <= '0;
      cmd_q     <= '0;
      wcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          wcnt <= '0;
          if (cmd) begin
            mem_addr  <= adr_sel ? reg_adr : PC;
            mem_wdata <= st_data;
            mem_we    <= mw_en;
            // A write suppresses any read committed with it.
            cmd_q.ir  <= ir_ld & ~mw_en;
            cmd_q.rd  <= s_sel & ~mw_en;
            cmd_q.inc <= pc_inc & ~pc_ld;
          end
        end
        ACCESS: begin
          wcnt <= wcnt + CW'(1);
          if (mem_ack) data_q <= mem_rdata;
        end
        DONE: begin
          if (cmd_q.ir) IR      <= data_q;
          if (cmd_q.rd) rd_data <= data_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_mem_if.sv
module tb_fetch_mem_if;

  localparam logic [15:0] RPC = 16'h0010;
  localparam int          TO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, pc_ld, pc_inc, pc_sel, ir_ld, adr_sel, s_sel, mw_en, mem_ack;
  logic [15:0] reg_adr, st_data, jmp_tgt, mem_rdata;
  logic        mem_req, mem_we, busy, err;
  logic [15:0] mem_addr, mem_wdata, PC, IR, rd_data;

  fetch_mem_if #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_sel(pc_sel),
    .ir_ld(ir_ld), .adr_sel(adr_sel), .s_sel(s_sel), .mw_en(mw_en),
    .reg_adr(reg_adr), .st_data(st_data), .jmp_tgt(jmp_tgt),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .PC(PC), .IR(IR),
    .rd_data(rd_data), .busy(busy), .err(err)
  );

  typedef struct {
    logic        ir, s, w, asel, inc, ld, sel;
    logic [15:0] radr, sd, jt, rdata;
    int          dly;
    logic [15:0] e_ir, e_pc, e_rd, e_addr;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  logic [15:0] m_pc, m_ir, m_rd;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pc_ld = 0; pc_inc = 0; pc_sel = 0; ir_ld = 0; adr_sel = 0; s_sel = 0; mw_en = 0;
  endtask

  task automatic scramble();
    pc_ld = 1'($urandom); pc_inc = 1'($urandom); pc_sel = 1'($urandom);
    ir_ld = 1'($urandom); adr_sel = 1'($urandom); s_sel = 1'($urandom);
    mw_en = 1'($urandom);
    reg_adr = 16'($urandom); st_data = 16'($urandom); jmp_tgt = 16'($urandom);
  endtask

  function automatic vec_t mk(input logic ir, s, w, asel, inc, ld, sel,
                              input logic [15:0] radr, sd, jt, rdata, input int dly,
                              input logic [15:0] e_ir, e_pc, e_rd, e_addr);
    vec_t v;
    v.ir = ir; v.s = s; v.w = w; v.asel = asel; v.inc = inc; v.ld = ld; v.sel = sel;
    v.radr = radr; v.sd = sd; v.jt = jt; v.rdata = rdata; v.dly = dly;
    v.e_ir = e_ir; v.e_pc = e_pc; v.e_rd = e_rd; v.e_addr = e_addr;
    return v;
  endfunction

  // Apply one control word at an IDLE cycle (called just after an edge)
  // and follow it through the access, checking bus and commit results.
  task automatic run(input vec_t v, input string tag);
    logic cmd;
    int   nbusy;
    cmd = v.ir | v.s | v.w;
    ir_ld = v.ir; s_sel = v.s; mw_en = v.w; adr_sel = v.asel; pc_inc = v.inc;
    pc_ld = v.ld; pc_sel = v.sel; reg_adr = v.radr; st_data = v.sd; jmp_tgt = v.jt;
    mem_ack = cmd ? 1'b0 : 1'($urandom);
    mem_rdata = 16'($urandom);
    nbusy = 0;
    #3;
    chk({tag, ".busy_idle"}, 16'(busy), 16'(cmd));
    if (busy) nbusy++;
    if (cmd) begin
      for (int i = 0; i <= v.dly; i++) begin
        tick();
        scramble();
        mem_ack   = (i == v.dly);
        mem_rdata = (i == v.dly) ? v.rdata : 16'($urandom);
        #3;
        if (busy) nbusy++;
        chk({tag, ".req"},  16'(mem_req), 16'h1);
        chk({tag, ".addr"}, mem_addr, v.e_addr);
        chk({tag, ".we"},   16'(mem_we), 16'(v.w));
        if (v.w) chk({tag, ".wdata"}, mem_wdata, v.sd);
      end
      tick();
      clr();
      mem_ack = 1'($urandom);
      mem_rdata = 16'($urandom);
      #3;
      chk({tag, ".done_busy"}, 16'(busy), 16'h0);
      chk({tag, ".done_req"},  16'(mem_req), 16'h0);
      chk({tag, ".nbusy"}, 16'(nbusy), 16'(v.dly + 2));
    end
    tick();
    clr();
    mem_ack = 0;
    #3;
    chk({tag, ".IR"}, IR, v.e_ir);
    chk({tag, ".PC"}, PC, v.e_pc);
    chk({tag, ".rd"}, rd_data, v.e_rd);
  endtask

  task automatic do_reset();
    tick();
    clr();
    mem_ack = 0;
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".PC"},    PC, RPC);
    chk({tag, ".IR"},    IR, 16'h0);
    chk({tag, ".rd"},    rd_data, 16'h0);
    chk({tag, ".req"},   16'(mem_req), 16'h0);
    chk({tag, ".we"},    16'(mem_we), 16'h0);
    chk({tag, ".addr"},  mem_addr, 16'h0);
    chk({tag, ".wdata"}, mem_wdata, 16'h0);
    chk({tag, ".err"},   16'(err), 16'h0);
    chk({tag, ".busy"},  16'(busy), 16'h0);
  endtask

  vec_t tbl[16];

  initial begin
    //           ir s w as in ld sl  radr     sd       jt       rdata    d   e_ir     e_pc     e_rd     e_addr
    tbl[0]  = mk(1,0,0,0, 1,0,0, 16'h0000,16'h0000,16'h0000,16'hE0C2,1, 16'hE0C2,16'h0011,16'h0000,16'h0010);
    tbl[1]  = mk(1,0,0,0, 1,0,0, 16'h0000,16'h0000,16'h0000,16'h1234,0, 16'h1234,16'h0012,16'h0000,16'h0011);
    tbl[2]  = mk(0,0,1,1, 0,0,0, 16'h0040,16'hBEEF,16'h0000,16'h5555,0, 16'h1234,16'h0012,16'h0000,16'h0040);
    tbl[3]  = mk(0,1,0,1, 0,0,0, 16'h0080,16'h0000,16'h0000,16'hA5A5,2, 16'h1234,16'h0012,16'hA5A5,16'h0080);
    tbl[4]  = mk(1,1,1,0, 0,0,0, 16'h0000,16'h7777,16'h0000,16'hFFFF,0, 16'h1234,16'h0012,16'hA5A5,16'h0012);
    tbl[5]  = mk(0,0,0,0, 0,1,1, 16'h0000,16'h0000,16'h0004,16'h0000,0, 16'h1234,16'h0004,16'hA5A5,16'h0000);
    tbl[6]  = mk(1,0,0,0, 1,0,0, 16'h0000,16'h0000,16'h0000,16'h20FE,1, 16'h20FE,16'h0005,16'hA5A5,16'h0004);
    tbl[7]  = mk(0,0,0,0, 0,1,0, 16'h0000,16'h0000,16'h0000,16'h0000,0, 16'h20FE,16'h0003,16'hA5A5,16'h0000);
    tbl[8]  = mk(0,0,0,0, 0,1,1, 16'h0000,16'h0000,16'h1234,16'h0000,0, 16'h20FE,16'h1234,16'hA5A5,16'h0000);
    tbl[9]  = mk(0,0,0,0, 0,1,1, 16'h0000,16'h0000,16'hFFFF,16'h0000,0, 16'h20FE,16'hFFFF,16'hA5A5,16'h0000);
    tbl[10] = mk(1,0,0,0, 1,0,0, 16'h0000,16'h0000,16'h0000,16'h0102,0, 16'h0102,16'h0000,16'hA5A5,16'hFFFF);
    tbl[11] = mk(1,0,0,0, 1,1,1, 16'h0000,16'h0000,16'h0200,16'h3003,0, 16'h3003,16'h0200,16'hA5A5,16'h0000);
    tbl[12] = mk(0,0,0,0, 0,1,0, 16'h0000,16'h0000,16'h0000,16'h0000,0, 16'h3003,16'h0203,16'hA5A5,16'h0000);
    tbl[13] = mk(0,1,0,1, 1,0,0, 16'h0300,16'h0000,16'h0000,16'h0BAD,3, 16'h3003,16'h0204,16'h0BAD,16'h0300);
    tbl[14] = mk(0,0,0,0, 1,0,0, 16'h0000,16'h0000,16'h0000,16'h0000,0, 16'h3003,16'h0204,16'h0BAD,16'h0000);
    tbl[15] = mk(1,1,0,0, 0,0,0, 16'h0000,16'h0000,16'h0000,16'hC0DE,4, 16'hC0DE,16'h0204,16'hC0DE,16'h0204);

    clr();
    reset = 0; mem_ack = 0; mem_rdata = 0; reg_adr = 0; st_data = 0; jmp_tgt = 0;
    tick();
    tick();
    reset = 1;
    #3;
    chk_reset_vals("rst0");

    tick();
    for (int i = 0; i < 16; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // randomized transactions against the reference model
    do_reset();
    m_pc = RPC; m_ir = 16'h0; m_rd = 16'h0;
    for (int k = 0; k < 80; k++) begin
      vec_t  v;
      logic  c;
      v.ir = 1'($urandom); v.s = 1'($urandom); v.w = 1'($urandom);
      v.asel = 1'($urandom); v.inc = 1'($urandom);
      v.ld = ($urandom_range(0, 3) == 0); v.sel = 1'($urandom);
      v.radr = 16'($urandom); v.sd = 16'($urandom); v.jt = 16'($urandom);
      v.rdata = 16'($urandom); v.dly = $urandom_range(0, 5);
      c = v.ir | v.s | v.w;
      v.e_addr = v.asel ? v.radr : m_pc;
      if (v.ld)         m_pc = v.sel ? v.jt : m_pc + {{8{m_ir[7]}}, m_ir[7:0]};
      else if (c & v.inc) m_pc = m_pc + 16'd1;
      if (v.ir & ~v.w) m_ir = v.rdata;
      if (v.s & ~v.w)  m_rd = v.rdata;
      v.e_ir = m_ir; v.e_pc = m_pc; v.e_rd = m_rd;
      run(v, $sformatf("rnd%0d", k));
    end

    // reset in the middle of an access, then a late ack
    do_reset();
    ir_ld = 1; pc_inc = 1;
    tick();
    clr();
    #3;
    chk("mid.req", 16'(mem_req), 16'h1);
    reset = 0;
    tick();
    reset = 1;
    mem_ack = 1;
    mem_rdata = 16'hDEAD;
    #3;
    chk("mid.req_after", 16'(mem_req), 16'h0);
    chk("mid.busy_after", 16'(busy), 16'h0);
    tick();
    mem_ack = 0;
    tick();
    #3;
    chk("mid.IR", IR, 16'h0);
    chk("mid.PC", PC, RPC);
    chk("mid.rd", rd_data, 16'h0);

    // timeout into the sticky error state
    tick();
    ir_ld = 1;
    #3;
    chk("to.busy_idle", 16'(busy), 16'h1);
    for (int i = 0; i < TO; i++) begin
      tick();
      clr();
      mem_ack = 0;
      #3;
      chk($sformatf("to.req%0d", i), 16'(mem_req), 16'h1);
    end
    tick();
    #3;
    chk("to.err", 16'(err), 16'h1);
    chk("to.busy", 16'(busy), 16'h1);
    chk("to.req_off", 16'(mem_req), 16'h0);
    tick();
    mem_ack = 1;
    mem_rdata = 16'h4444;
    tick();
    mem_ack = 0;
    #3;
    chk("to.err_sticky", 16'(err), 16'h1);
    chk("to.busy_sticky", 16'(busy), 16'h1);
    chk("to.IR", IR, 16'h0);
    reset = 0;
    tick();
    reset = 1;
    #3;
    chk_reset_vals("rst1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
